// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with normal or show-ahead read
// mode, registered almost-full/almost-empty flags and one-cycle
// overflow/underflow error pulses. Drop-in successor to the vendor scfifo.
module sync_fifo #(
    parameter int WIDTH        = 64,
    parameter int DEPTH_LOG2   = 8,
    parameter int SHOWAHEAD    = 0,
    parameter int ALMOST_FULL  = (2 ** DEPTH_LOG2) - 4,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic [WIDTH-1:0]      data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [WIDTH-1:0]      q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t AE_THR   = cnt_t'(ALMOST_EMPTY);
    localparam cnt_t AF_THR   = cnt_t'(ALMOST_FULL);

    logic [WIDTH-1:0] ram [DEPTH];

    ptr_t wptr, rptr;
    ptr_t wptr_next, rptr_next;
    cnt_t count_next;
    logic rd_acc, wr_acc;
    logic fwd;

    // Accept decisions, next pointers and next count
    always_comb begin
        rd_acc     = rdreq && !empty;
        wr_acc     = wrreq && (!full || rd_acc);
        wptr_next  = wr_acc ? wptr + PTR_ONE : wptr;
        rptr_next  = rd_acc ? rptr + PTR_ONE : rptr;
        count_next = usedw;
        if (wr_acc && !rd_acc)
            count_next = usedw + CNT_ONE;
        else if (rd_acc && !wr_acc)
            count_next = usedw - CNT_ONE;
        // In show-ahead mode the word being written becomes the head when
        // nothing else remains after this cycle's pop; the RAM cannot supply
        // it yet, so it is forwarded straight from the data input.
        fwd = wr_acc && (empty || (usedw == CNT_ONE && rd_acc));
    end

    // Storage write; RAM contents survive sclr
    always_ff @(posedge clock) begin
        if (!sclr && wr_acc)
            ram[wptr] <= data;
    end

    // Pointers, count, registered flags and error pulses
    always_ff @(posedge clock) begin
        if (sclr) begin
            wptr         <= '0;
            rptr         <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= (ALMOST_EMPTY > 0);
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wptr         <= wptr_next;
            rptr         <= rptr_next;
            usedw        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CNT_FULL);
            almost_empty <= (count_next < AE_THR);
            almost_full  <= (count_next >= AF_THR);
            overflow     <= wrreq && !wr_acc;
            underflow    <= rdreq && !rd_acc;
        end
    end

    // Read data register: loaded on pop (normal) or tracks head word (show-ahead)
    always_ff @(posedge clock) begin
        if (sclr) begin
            q <= '0;
        end else if (SHOWAHEAD != 0) begin
            if (fwd)
                q <= data;
            else if (count_next != '0)
                q <= ram[rptr_next];
        end else if (rd_acc) begin
            q <= ram[rptr];
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven and scoreboard checks of sync_fifo in default
// (normal, 64x256) configuration plus a small show-ahead instance.
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        sclr = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
    logic [63:0] data = '0;
    logic [63:0] q;
    logic        empty, full, almost_empty, almost_full, overflow, underflow;
    logic [8:0]  usedw;

    sync_fifo dut (
        .clock(clk), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .usedw(usedw), .overflow(overflow),
        .underflow(underflow)
    );

    // Show-ahead instance, 16 bits x 4 words
    logic        sa_sclr = 1'b0, sa_wrreq = 1'b0, sa_rdreq = 1'b0;
    logic [15:0] sa_data = '0;
    logic [15:0] sa_q;
    logic        sa_empty, sa_full, sa_aempty, sa_afull, sa_ovf, sa_unf;
    logic [2:0]  sa_usedw;

    sync_fifo #(.WIDTH(16), .DEPTH_LOG2(2), .SHOWAHEAD(1)) dut_sa (
        .clock(clk), .sclr(sa_sclr), .data(sa_data), .wrreq(sa_wrreq), .rdreq(sa_rdreq),
        .q(sa_q), .empty(sa_empty), .full(sa_full), .almost_empty(sa_aempty),
        .almost_full(sa_afull), .usedw(sa_usedw), .overflow(sa_ovf),
        .underflow(sa_unf)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] mdl[$];     // reference FIFO contents
    logic [63:0] exp_q[$];   // scoreboard of words expected on q
    logic [63:0] last_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the default FIFO with full model-based checking
    task automatic cyc(input logic wr, input logic rd, input logic [63:0] d, input logic clr);
        logic racc, wacc, e_ovf, e_unf;
        racc = 1'b0; wacc = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
        if (clr) begin
            mdl.delete();
            exp_q.delete();
        end else begin
            racc  = rd && (mdl.size() != 0);
            wacc  = wr && (mdl.size() < 256 || racc);
            e_ovf = wr && !wacc;
            e_unf = rd && !racc;
            if (racc) exp_q.push_back(mdl.pop_front());
            if (wacc) mdl.push_back(d);
        end
        sclr = clr; wrreq = wr; rdreq = rd; data = d;
        @(posedge clk); #1;
        sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
        chk("usedw",        64'(usedw),        64'(mdl.size()));
        chk("empty",        64'(empty),        64'(mdl.size() == 0));
        chk("full",         64'(full),         64'(mdl.size() == 256));
        chk("almost_empty", 64'(almost_empty), 64'(mdl.size() < 4));
        chk("almost_full",  64'(almost_full),  64'(mdl.size() >= 252));
        chk("overflow",     64'(overflow),     64'(e_ovf));
        chk("underflow",    64'(underflow),    64'(e_unf));
        if (clr) begin
            last_q = '0;
            chk("q_reset", q, last_q);
        end else if (racc) begin
            last_q = exp_q.pop_front();
            chk("q_read", q, last_q);
        end else begin
            chk("q_hold", q, last_q);
        end
    endtask

    task automatic sa_step(input logic wr, input logic rd, input logic [15:0] d, input logic clr);
        sa_sclr = clr; sa_wrreq = wr; sa_rdreq = rd; sa_data = d;
        @(posedge clk); #1;
        sa_sclr = 1'b0; sa_wrreq = 1'b0; sa_rdreq = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [63:0] d;
        int          exp_used;
        logic        exp_qv;
        logic [63:0] exp_qd;
    } vec_t;

    vec_t vt[7];

    initial begin
        last_q = '0;
        vt[0] = '{1'b1, 1'b0, 64'hDEA1BEE2, 1, 1'b0, 64'h0};
        vt[1] = '{1'b1, 1'b0, 64'hDEA3BEE4, 2, 1'b0, 64'h0};
        vt[2] = '{1'b1, 1'b0, 64'hDEA5BEE6, 3, 1'b0, 64'h0};
        vt[3] = '{1'b0, 1'b0, 64'h0,        3, 1'b0, 64'h0};
        vt[4] = '{1'b0, 1'b1, 64'h0,        2, 1'b1, 64'hDEA1BEE2};
        vt[5] = '{1'b0, 1'b1, 64'h0,        1, 1'b1, 64'hDEA3BEE4};
        vt[6] = '{1'b0, 1'b1, 64'h0,        0, 1'b1, 64'hDEA5BEE6};

        // Reset state
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("rst_almost_empty", 64'(almost_empty), 64'd1);

        // Three writes, idle, three reads
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].wr, vt[i].rd, vt[i].d, 1'b0);
            chk("tbl_usedw", 64'(usedw), 64'(vt[i].exp_used));
            if (vt[i].exp_qv) chk("tbl_q", q, vt[i].exp_qd);
        end
        chk("tbl_empty_end", 64'(empty), 64'd1);

        // Underflow on empty, then read+write on empty
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("unf_q_unchanged", q, 64'hDEA5BEE6);
        cyc(1'b1, 1'b1, 64'h55, 1'b0);
        chk("unf_rw_usedw", 64'(usedw), 64'd1);
        cyc(1'b0, 1'b1, '0, 1'b0);

        // Fill 256 (value = index), overflow, full read+write, drain
        for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 64'(i), 1'b0);
        chk("fill_full", 64'(full), 64'd1);
        cyc(1'b1, 1'b0, 64'hFFFF, 1'b0);
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_usedw", 64'(usedw), 64'd256);
        cyc(1'b1, 1'b1, 64'hABCD, 1'b0);
        chk("fullrw_full", 64'(full), 64'd1);
        chk("fullrw_q", q, 64'd0);
        chk("fullrw_noovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 256; i++) cyc(1'b0, 1'b1, '0, 1'b0);
        chk("drain_last", q, 64'hABCD);
        chk("drain_empty", 64'(empty), 64'd1);

        // Reset mid-burst discards stored words
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 64'h100 + 64'(i), 1'b0);
        wrreq = 1'b1; rdreq = 1'b1; data = 64'h999; sclr = 1'b1;
        cyc(1'b1, 1'b1, 64'h999, 1'b1);
        chk("clr_usedw", 64'(usedw), 64'd0);
        chk("clr_q", q, 64'd0);
        cyc(1'b1, 1'b0, 64'h77, 1'b0);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("clr_newdata", q, 64'h77);
        chk("clr_empty", 64'(empty), 64'd1);

        // Show-ahead instance
        sa_step(1'b0, 1'b0, '0, 1'b1);
        chk("sa_rst_empty", 64'(sa_empty), 64'd1);
        chk("sa_rst_q", 64'(sa_q), 64'd0);
        sa_step(1'b1, 1'b0, 16'h1111, 1'b0);
        chk("sa_w1_empty", 64'(sa_empty), 64'd0);
        chk("sa_w1_q", 64'(sa_q), 64'h1111);
        sa_step(1'b0, 1'b0, '0, 1'b0);
        chk("sa_idle_q", 64'(sa_q), 64'h1111);
        sa_step(1'b1, 1'b1, 16'h2222, 1'b0);
        chk("sa_wr_q", 64'(sa_q), 64'h2222);
        chk("sa_wr_usedw", 64'(sa_usedw), 64'd1);
        sa_step(1'b1, 1'b0, 16'h3333, 1'b0);
        sa_step(1'b1, 1'b0, 16'h4444, 1'b0);
        sa_step(1'b1, 1'b0, 16'h5555, 1'b0);
        chk("sa_full", 64'(sa_full), 64'd1);
        chk("sa_full_usedw", 64'(sa_usedw), 64'd4);
        chk("sa_full_q", 64'(sa_q), 64'h2222);
        sa_step(1'b1, 1'b0, 16'h6666, 1'b0);
        chk("sa_ovf", 64'(sa_ovf), 64'd1);
        sa_step(1'b0, 1'b1, '0, 1'b0);
        chk("sa_pop1", 64'(sa_q), 64'h3333);
        sa_step(1'b0, 1'b1, '0, 1'b0);
        chk("sa_pop2", 64'(sa_q), 64'h4444);
        sa_step(1'b0, 1'b1, '0, 1'b0);
        chk("sa_pop3", 64'(sa_q), 64'h5555);
        sa_step(1'b0, 1'b1, '0, 1'b0);
        chk("sa_drained", 64'(sa_empty), 64'd1);
        sa_step(1'b0, 1'b1, '0, 1'b0);
        chk("sa_unf", 64'(sa_unf), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
